coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end coin acceptor that produces the 2-bit coin code consumed by the vending-machine controller. It synchronises and debounces two raw coin-slot sensors, one for 0.5 yuan and one for 1 yuan. It emits a single-cycle coin code per physical coin, enforces a minimum gap between coins, and flags rejects and jams. It sits between the slot hardware pins and the vending FSM's coin input.

Parameters:
DEB_CYCLES, 4, consecutive synchronised high samples needed to qualify a coin; legal range 1..255.
GAP_CYCLES, 8, cycles after sensor release during which sensors are ignored; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sense_05  input  1  raw 0.5 yuan slot sensor, asynchronous; high while a coin passes
sense_10  input  1  raw 1 yuan slot sensor, asynchronous; high while a coin passes
accept_en  input  1  high when the downstream controller can take a coin
coin  output  2  one-cycle coin code: 01 = 0.5 yuan, 10 = 1 yuan, 00 = none; 11 never driven
reject  output  1  one-cycle pulse when a qualified coin arrives while accept_en is low
jam  output  1  level; high while both sensors are active together

Behaviour:
- Reset and clocking:
  - Single clock domain: clk.
  - Reset is synchronous and active-high (rst).
  - On reset: sync flops = 0, state = IDLE, counter = 0, coin = 00, reject = 0, jam = 0.
  - Asserting rst mid-operation discards any pending coin. No output pulse is produced for it.
- Synchroniser: 2-flop synchroniser per sensor. All decisions use the synchronised values s05 and s10.
- All outputs are registered.
- State machine states: IDLE, DEB, EMIT, WAIT_REL, GAP, JAM.
- IDLE:
  - Exactly one of s05/s10 high: latch kind (05 or 10), set cnt = 1, go to DEB.
  - Both high: go to JAM.
  - Otherwise stay in IDLE.
- DEB:
  - Other sensor high: go to JAM.
  - Latched sensor low before the count completes: glitch. Go to IDLE with no output.
  - Latched sensor high: cnt++.
  - When DEB_CYCLES consecutive high samples have been seen, the coin is qualified.
  - At qualification, sample accept_en:
    - 1: go to EMIT.
    - 0: pulse reject for one cycle, go to WAIT_REL.
- EMIT: coin = latched code for exactly one cycle, then go to WAIT_REL.
- WAIT_REL: stay until s05 = 0 and s10 = 0. Then clear cnt and go to GAP. A coin held in the slot never re-emits.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - Sensors are ignored in GAP, including a both-high condition.
- JAM:
  - jam = 1 for the whole state.
  - Exit requires both sensors low for DEB_CYCLES consecutive cycles; then go to GAP with jam = 0.
  - No coin or reject pulse is produced for a jam.
- Latency: the first clock edge that samples a raw sense high is edge N0. The coin (or reject) pulse is high in the cycle following edge N0+2+DEB_CYCLES, provided the sensor stays high throughout.
- Gap between emissions: at least one pulse-free cycle.
- Pulse rules:
  - coin and reject are never high in the same cycle.
  - At most one coin or reject pulse per sensor assertion.

Optional Feature:
Macro: COIN_TOTAL_EN.
- When defined:
  - Extra ports: clr_total (input, 1) and total (output, 16).
  - total counts accepted value in 0.5-yuan units: +1 per emitted 01, +2 per emitted 10. Rejected coins are not counted.
  - total saturates at 16'hFFFF.
  - clr_total = 1 clears total the next cycle and takes priority over a same-cycle increment.
  - rst clears total.
- When not defined: neither port exists and no counter logic is present.

Test Plan:
1. DEB_CYCLES=4: raise sense_05 at edge N0 and hold for 20 cycles -> coin = 01 for exactly one cycle after edge N0+6; no second pulse while held.
2. sense_10 high for 3 cycles then low -> no coin, no reject; state returns to IDLE.
3. accept_en = 0, sense_10 held 10 cycles -> reject pulses once and coin stays 00. Repeat with accept_en = 1 -> coin = 10 once.
4. Both sensors high together -> jam = 1 with no coin. Release both -> jam falls after DEB_CYCLES low samples. A following valid coin is accepted after GAP_CYCLES.
5. Coin released, then a second coin raised 3 cycles later (inside GAP=8) and held 20 cycles -> exactly one emission for the second coin, occurring after GAP ends plus the debounce time.
6. COIN_TOTAL_EN: coins 01, 10, 10 -> total = 5. Assert rst during DEB -> no pulse and total = 0. Assert clr_total on the same cycle as an emission -> total = 0.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces two raw coin-slot sensors and
// turns each physical coin into a single-cycle coin code for the vending
// controller, with reject, jam and inter-coin gap handling.
//
// Optional feature: define COIN_TOTAL_EN to add clr_total/total, a saturating
// count of accepted value in 0.5-yuan units.
//
// Handshake: there is no back-pressure. coin and reject are one-cycle strobes
// the consumer must take in the cycle they are high. accept_en is a level
// sampled only at the moment a coin qualifies; it decides coin versus reject.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sense_05,
  input  logic        sense_10,
  input  logic        accept_en,
`ifdef COIN_TOTAL_EN
  input  logic        clr_total,
  output logic [15:0] total,
`endif
  output logic [1:0]  coin,
  output logic        reject,
  output logic        jam,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEB      = 3'd1;
  localparam logic [2:0] ST_EMIT     = 3'd2;
  localparam logic [2:0] ST_WAIT_REL = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_JAM      = 3'd5;

  // The IDLE sample counts as the first high sample; a coin qualifies on the
  // sample after cnt has reached DEB_CYCLES, which places the pulse in the
  // cycle after edge N0+2+DEB_CYCLES.
  localparam logic [7:0] DEB_N    = 8'(DEB_CYCLES);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic       sync05_q, sync10_q;
  logic       s05, s10;
  logic [2:0] state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       kind_10, kind_10_d;
  logic [1:0] coin_d;
  logic       reject_d;
  logic       latched_s, other_s;
  logic [1:0] kind_code;

  assign latched_s = kind_10 ? s10 : s05;
  assign other_s   = kind_10 ? s05 : s10;
  assign kind_code = kind_10 ? 2'b10 : 2'b01;
  assign state_dbg = state;

  // Two-flop synchronisers for the asynchronous slot sensors.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync05_q <= 1'b0;
      sync10_q <= 1'b0;
      s05      <= 1'b0;
      s10      <= 1'b0;
    end else begin
      sync05_q <= sense_05;
      sync10_q <= sense_10;
      s05      <= sync05_q;
      s10      <= sync10_q;
    end
  end

  // Next-state, counter and output-pulse decode.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    kind_10_d = kind_10;
    coin_d    = 2'b00;
    reject_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s05 && s10) begin
          state_d = ST_JAM;
          cnt_d   = 8'd0;
        end else if (s05 || s10) begin
          state_d   = ST_DEB;
          kind_10_d = s10;
          cnt_d     = 8'd1;
        end
      end
      ST_DEB: begin
        if (other_s) begin
          state_d = ST_JAM;
          cnt_d   = 8'd0;
        end else if (!latched_s) begin
          // Glitch: sensor dropped before qualifying, no output.
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt >= DEB_N) begin
          if (accept_en) begin
            coin_d  = kind_code;
            state_d = ST_EMIT;
          end else begin
            reject_d = 1'b1;
            state_d  = ST_WAIT_REL;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      ST_EMIT: begin
        // coin is high for exactly this one cycle.
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        // A coin parked in the slot stays here and never re-emits.
        if (!s05 && !s10) begin
          state_d = ST_GAP;
          cnt_d   = 8'd0;
        end
      end
      ST_GAP: begin
        // Sensors are deliberately ignored here, including a jam pattern.
        if (cnt >= GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      ST_JAM: begin
        if (s05 || s10) begin
          cnt_d = 8'd0;
        end else if (cnt >= DEB_LAST) begin
          state_d = ST_GAP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      kind_10 <= 1'b0;
      coin    <= 2'b00;
      reject  <= 1'b0;
      jam     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      kind_10 <= kind_10_d;
      coin    <= coin_d;
      reject  <= reject_d;
      jam     <= (state_d == ST_JAM);
    end
  end

`ifdef COIN_TOTAL_EN
  // The coin code's numeric value is its worth in 0.5-yuan units.
  logic [16:0] total_sum;
  assign total_sum = {1'b0, total} + {15'd0, coin};

  // Saturating accepted-value total; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      total <= 16'd0;
    end else if (clr_total) begin
      total <= 16'd0;
    end else if (coin != 2'b00) begin
      total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEB_CYCLES=4, GAP_CYCLES=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_05;
  logic       sense_10;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic [2:0] state_dbg;
`ifdef COIN_TOTAL_EN
  logic        clr_total;
  logic [15:0] total;
`endif

  int passed = 0;
  int checks = 0;

  coin_acceptor #(.DEB_CYCLES(4), .GAP_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sense_05  (sense_05),
    .sense_10  (sense_10),
    .accept_en (accept_en),
`ifdef COIN_TOTAL_EN
    .clr_total (clr_total),
    .total     (total),
`endif
    .coin      (coin),
    .reject    (reject),
    .jam       (jam),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  // Hold one sensor for 'hold' cycles, then release and let the gap expire.
  task automatic drive_coin(input bit is_10, input int hold);
    if (is_10) sense_10 = 1'b1; else sense_05 = 1'b1;
    idle_cycles(hold);
    sense_05 = 1'b0;
    sense_10 = 1'b0;
    idle_cycles(20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sense_05 = 1'b0;
    sense_10 = 1'b0;
    accept_en = 1'b1;
`ifdef COIN_TOTAL_EN
    clr_total = 1'b0;
`endif
    idle_cycles(3);
    rst = 1'b0;
    tick();
    checks++; if (coin !== 2'b00) $display("FAIL reset_coin got=%b exp=00", coin); else passed++;
    checks++; if (reject !== 1'b0) $display("FAIL reset_reject got=%b exp=0", reject); else passed++;
    checks++; if (jam !== 1'b0) $display("FAIL reset_jam got=%b exp=0", jam); else passed++;
    checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg); else passed++;
`ifdef COIN_TOTAL_EN
    checks++; if (total !== 16'd0) $display("FAIL reset_total got=%0d exp=0", total); else passed++;
`endif
  endtask

  task automatic test_single_coin();
    int n = 0;
    int at = 0;
    int bad = 0;
    sense_05 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (coin == 2'b01) begin n++; if (at == 0) at = i; end
      if (coin == 2'b11 || coin == 2'b10 || reject) bad++;
    end
    sense_05 = 1'b0;
    idle_cycles(20);
    checks++; if (n !== 1) $display("FAIL single_coin_count got=%0d exp=1", n); else passed++;
    checks++; if (at !== 7) $display("FAIL single_coin_latency got=%0d exp=7", at); else passed++;
    checks++; if (bad !== 0) $display("FAIL single_coin_other_pulses got=%0d exp=0", bad); else passed++;
  endtask

  task automatic test_glitch();
    int pulses = 0;
    sense_10 = 1'b1;
    idle_cycles(3);
    sense_10 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (coin != 2'b00 || reject) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL glitch_pulses got=%0d exp=0", pulses); else passed++;
    checks++; if (state_dbg !== 3'd0) $display("FAIL glitch_state got=%0d exp=0", state_dbg); else passed++;
  endtask

  task automatic test_reject_accept();
    int rej = 0;
    int cn = 0;
    int rej_at = 0;
    int both = 0;
    accept_en = 1'b0;
    sense_10 = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 11) sense_10 = 1'b0;
      tick();
      if (reject) begin rej++; if (rej_at == 0) rej_at = i; end
      if (coin != 2'b00) cn++;
      if (reject && coin != 2'b00) both++;
    end
    checks++; if (rej !== 1) $display("FAIL reject_count got=%0d exp=1", rej); else passed++;
    checks++; if (rej_at !== 7) $display("FAIL reject_latency got=%0d exp=7", rej_at); else passed++;
    checks++; if (cn !== 0) $display("FAIL reject_coin_count got=%0d exp=0", cn); else passed++;
    accept_en = 1'b1;
    rej = 0;
    cn = 0;
    sense_10 = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 11) sense_10 = 1'b0;
      tick();
      if (reject) rej++;
      if (coin == 2'b10) cn++;
      if (reject && coin != 2'b00) both++;
    end
    checks++; if (cn !== 1) $display("FAIL accept_coin10_count got=%0d exp=1", cn); else passed++;
    checks++; if (rej !== 0) $display("FAIL accept_reject_count got=%0d exp=0", rej); else passed++;
    checks++; if (both !== 0) $display("FAIL coin_and_reject_overlap got=%0d exp=0", both); else passed++;
  endtask

  task automatic test_jam();
    int pulses = 0;
    int fall_at = 0;
    int n = 0;
    int at = 0;
    sense_05 = 1'b1;
    sense_10 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (coin != 2'b00 || reject) pulses++;
    end
    checks++; if (jam !== 1'b1) $display("FAIL jam_high got=%b exp=1", jam); else passed++;
    sense_05 = 1'b0;
    sense_10 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (coin != 2'b00 || reject) pulses++;
      if (jam == 1'b0 && fall_at == 0) fall_at = i;
    end
    checks++; if (fall_at !== 6) $display("FAIL jam_fall_cycle got=%0d exp=6", fall_at); else passed++;
    checks++; if (pulses !== 0) $display("FAIL jam_pulses got=%0d exp=0", pulses); else passed++;
    // Coin raised immediately; it is only seen once the gap has expired.
    sense_05 = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (coin == 2'b01) begin n++; if (at == 0) at = j; end
    end
    sense_05 = 1'b0;
    idle_cycles(20);
    checks++; if (n !== 1) $display("FAIL post_jam_coin_count got=%0d exp=1", n); else passed++;
    checks++; if (at !== 13) $display("FAIL post_jam_coin_cycle got=%0d exp=13", at); else passed++;
  endtask

  task automatic test_back_to_back();
    int n1 = 0;
    int n2 = 0;
    int at = 0;
    sense_05 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (coin == 2'b01) n1++;
    end
    sense_05 = 1'b0;
    idle_cycles(3);
    sense_05 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (coin == 2'b01) begin n2++; if (at == 0) at = k; end
    end
    sense_05 = 1'b0;
    idle_cycles(20);
    checks++; if (n1 !== 1) $display("FAIL b2b_first_count got=%0d exp=1", n1); else passed++;
    checks++; if (n2 !== 1) $display("FAIL b2b_second_count got=%0d exp=1", n2); else passed++;
    checks++; if (at !== 13) $display("FAIL b2b_second_cycle got=%0d exp=13", at); else passed++;
  endtask

`ifdef COIN_TOTAL_EN
  task automatic test_total();
    int pulses = 0;
    drive_coin(1'b0, 10);
    drive_coin(1'b1, 10);
    drive_coin(1'b1, 10);
    checks++; if (total !== 16'd5) $display("FAIL total_sum got=%0d exp=5", total); else passed++;
    // Reset while debouncing discards the coin.
    sense_10 = 1'b1;
    idle_cycles(4);
    rst = 1'b1;
    sense_10 = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (coin != 2'b00 || reject) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL rst_deb_pulses got=%0d exp=0", pulses); else passed++;
    checks++; if (total !== 16'd0) $display("FAIL rst_deb_total got=%0d exp=0", total); else passed++;
    drive_coin(1'b0, 10);
    checks++; if (total !== 16'd1) $display("FAIL total_before_clr got=%0d exp=1", total); else passed++;
    sense_10 = 1'b1;
    idle_cycles(7);
    checks++; if (coin !== 2'b10) $display("FAIL clr_emit_coin got=%b exp=10", coin); else passed++;
    clr_total = 1'b1;
    tick();
    clr_total = 1'b0;
    checks++; if (total !== 16'd0) $display("FAIL clr_priority_total got=%0d exp=0", total); else passed++;
    sense_10 = 1'b0;
    idle_cycles(20);
  endtask
`endif

  initial begin
    test_reset();
    test_single_coin();
    test_glitch();
    test_reject_accept();
    test_jam();
    test_back_to_back();
`ifdef COIN_TOTAL_EN
    test_total();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
